// File: rtl/cache_flush_seq.sv
// Tag-array invalidation sequencer for one set-associative write-through L1 cache.
// Optional arbiter stall counter enabled by defining CACHE_FLUSH_STALL_CNT_EN.
module cache_flush_seq #(
    parameter int BYTE_SIZE  = 4993,
    parameter int SET_ASSOC  = 2,
    parameter int LINE_WIDTH = 128,
    localparam int NUM_SETS  = BYTE_SIZE / (SET_ASSOC * LINE_WIDTH / 8),
    localparam int IDX_W     = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 init_done_o,
    output logic                 flush_ack_o,
    output logic                 tag_req_o,
    input  logic                 tag_gnt_i,
    output logic                 tag_we_o,
    output logic [IDX_W-1:0]     tag_idx_o,
    output logic [SET_ASSOC-1:0] tag_way_o,
    output logic                 tag_valid_o,
    output logic [31:0]          stall_cnt_o
);

    // state   | meaning
    // S_INIT  | post-reset sweep of every set, busy, no ack
    // S_IDLE  | waiting for flush_i, lookups allowed
    // S_SWEEP | flush-initiated sweep, one set per grant
    // S_DONE  | one-cycle ack, re-sweep if a flush is pending

    if (NUM_SETS < 1) begin : g_bad_geometry
        $error("cache_flush_seq: geometry yields zero sets");
    end
    if (SET_ASSOC < 1 || SET_ASSOC > 8) begin : g_bad_assoc
        $error("cache_flush_seq: SET_ASSOC must be 1..8");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             req_q, busy_q, ack_q;
    logic             fire, last;

    assign fire = req_q & tag_gnt_i;
    assign last = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        pend_d  = pend_q | (flush_i & (state_q != S_IDLE));
        case (state_q)
            S_INIT: begin
                if (fire) begin
                    if (last) begin
                        idx_d  = '0;
                        done_d = 1'b1;
                        // A flush seen during the init sweep gets its own full sweep and ack.
                        if (pend_q | flush_i) begin
                            state_d = S_SWEEP;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_IDLE: begin
                if (flush_i) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end
            end
            S_SWEEP: begin
                if (fire) begin
                    if (last) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                // Any number of requests since the sweep started collapse into one repeat.
                if (pend_q | flush_i) begin
                    state_d = S_SWEEP;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            req_q   <= (state_d == S_INIT) || (state_d == S_SWEEP);
            busy_q  <= (state_d != S_IDLE);
            ack_q   <= (state_d == S_DONE);
        end
    end

    assign busy_o      = busy_q;
    assign init_done_o = done_q;
    assign flush_ack_o = ack_q;
    assign tag_req_o   = req_q;
    assign tag_we_o    = req_q;
    assign tag_idx_o   = idx_q;
    assign tag_way_o   = {SET_ASSOC{req_q}};
    assign tag_valid_o = 1'b0;

`ifdef CACHE_FLUSH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (req_q && !tag_gnt_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cache_flush_seq.sv
// Self-checking bench for cache_flush_seq: scoreboarded index stream, table-driven flush scenarios.
module tb_cache_flush_seq;
    localparam int N  = 156;
    localparam int N2 = 115;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic gnt = 1'b1;

    logic        busy, init_done, ack, req, we, valid;
    logic [7:0]  idx;
    logic [1:0]  way;
    logic [31:0] stall;

    logic        busy2, init_done2, ack2, req2, we2, valid2;
    logic [6:0]  idx2;
    logic [1:0]  way2;
    logic [31:0] stall2;

    cache_flush_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy),
        .init_done_o(init_done), .flush_ack_o(ack), .tag_req_o(req),
        .tag_gnt_i(gnt), .tag_we_o(we), .tag_idx_o(idx), .tag_way_o(way),
        .tag_valid_o(valid), .stall_cnt_o(stall)
    );

    cache_flush_seq #(.BYTE_SIZE(3709), .SET_ASSOC(2), .LINE_WIDTH(128)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .busy_o(busy2),
        .init_done_o(init_done2), .flush_ack_o(ack2), .tag_req_o(req2),
        .tag_gnt_i(1'b1), .tag_we_o(we2), .tag_idx_o(idx2), .tag_way_o(way2),
        .tag_valid_o(valid2), .stall_cnt_o(stall2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int n_sweep_flush;
        bit done_flush;
        int exp_acks;
        int exp_sweeps;
        int exp_stall;
    } row_t;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int fires = 0, acks = 0, busy_rises = 0;
    int gnt_period = 1, req_cnt = 0;
    int fires2 = 0, max2 = 0, last2 = 0;
    logic busy_prev = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_idx = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_sweep();
        for (int k = 0; k < N; k++) exp_q.push_back(k);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({nm, "_idle_timeout"}, (n >= budget) ? 1 : 0, 0);
    endtask

    // Grant driver and output monitor share one process so the grant for the
    // coming edge is settled before the monitor evaluates it.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_prev  = 1'b0;
                prev_stall = 1'b0;
                req_cnt    = 0;
                fires2     = 0;
                max2       = 0;
                last2      = 0;
                gnt        = (gnt_period == 1);
            end else begin
                if (req) begin
                    gnt = ((req_cnt % gnt_period) == gnt_period - 1);
                    req_cnt++;
                end else begin
                    gnt = (gnt_period == 1);
                    req_cnt = 0;
                end
                chk("way_mask", way, req ? 2'b11 : 2'b00);
                chk("we_eq_req", we, req);
                chk("valid_zero", valid, 0);
                if (prev_stall) begin
                    chk("hold_req", req, 1);
                    chk("hold_idx", idx, prev_idx);
                end
                prev_stall = req && !gnt;
                prev_idx   = idx;
                if (req && gnt) begin
                    fires++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL idx_unexpected: got %0d expected none", idx);
                    end else begin
                        chk("idx_seq", idx, exp_q.pop_front());
                    end
                end
                if (ack) acks++;
                if (busy && !busy_prev) busy_rises++;
                busy_prev = busy;
                if (req2) begin
                    fires2++;
                    if (idx2 > max2) max2 = idx2;
                    last2 = idx2;
                end
            end
        end
    end

    task automatic run_row(input row_t r, input int i);
        int base_f, base_a, base_r, n;
        longint base_s;
        base_f = fires;
        base_a = acks;
        base_r = busy_rises;
        base_s = stall;
        gnt_period = r.period;
        for (int s = 0; s < r.exp_sweeps; s++) push_sweep();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        for (int j = 0; j < r.n_sweep_flush; j++) begin
            repeat (30) @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk); #1 flush = 1'b0;
        end
        if (r.done_flush) begin
            n = 0;
            while (!ack && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("done_wait_timeout", (n >= 3000) ? 1 : 0, 0);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        wait_idle("row", 4000);
        chk($sformatf("row%0d_acks", i), acks - base_a, r.exp_acks);
        chk($sformatf("row%0d_grants", i), fires - base_f, r.exp_sweeps * N);
        chk($sformatf("row%0d_busy_rises", i), busy_rises - base_r, 1);
        chk($sformatf("row%0d_queue_left", i), exp_q.size(), 0);
`ifdef CACHE_FLUSH_STALL_CNT_EN
        chk($sformatf("row%0d_stall", i), stall - base_s, r.exp_stall);
`endif
        gnt_period = 1;
    endtask

    initial begin
        row_t rows[4];
        int rc, n, base_a;
        rows[0] = '{period: 1, n_sweep_flush: 0, done_flush: 0, exp_acks: 1, exp_sweeps: 1, exp_stall: 0};
        rows[1] = '{period: 3, n_sweep_flush: 0, done_flush: 0, exp_acks: 1, exp_sweeps: 1, exp_stall: 312};
        rows[2] = '{period: 1, n_sweep_flush: 2, done_flush: 1, exp_acks: 2, exp_sweeps: 2, exp_stall: 0};
        rows[3] = '{period: 2, n_sweep_flush: 1, done_flush: 0, exp_acks: 2, exp_sweeps: 2, exp_stall: 312};

        // Reset state and post-reset init sweep.
        push_sweep();
        @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ack", ack, 0);
        chk("rst_idx", idx, 0);
        chk("rst_way", way, 0);
        chk("rst_stall", stall, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init_req_rise", req, 1);
        chk("init_busy", busy, 1);
        rc = 0;
        n = 0;
        while (!init_done && n < 400) begin
            @(negedge clk);
            if (req) rc++;
            n++;
        end
        #1;
        chk("init_req_cycles", rc, N);
        chk("init_done_req_low", req, 0);
        chk("init_done_busy", busy, 0);
        chk("init_no_ack", acks, 0);
        chk("init_queue_left", exp_q.size(), 0);

        // Flush from IDLE: exact request latency and ack position.
        push_sweep();
        base_a = acks;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("lat_req", req, 1);
        chk("lat_busy", busy, 1);
        rc = 0;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (!busy) rc++;
            if (ack) begin
                n = k;
                break;
            end
        end
        chk("lat_ack_edge", n, N);
        chk("lat_busy_drop", rc, 0);
        @(posedge clk); #1;
        chk("lat_ack_pulse", ack, 0);
        chk("lat_idle_busy", busy, 0);
        #1;
        chk("lat_ack_count", acks - base_a, 1);

        for (int i = 0; i < 4; i++) run_row(rows[i], i);

        // Asynchronous reset mid-sweep, then flush during the init sweep.
        gnt_period = 1;
        push_sweep();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        n = 0;
        while (idx != 8'd80 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reach_80", (n >= 400) ? 1 : 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_req", req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_idx", idx, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_stall", stall, 0);
        exp_q.delete();
        base_a = acks;
        repeat (3) @(negedge clk);
        push_sweep();
        push_sweep();
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("initflush_busy", busy, 1);
        n = 0;
        while (!(init_done && !busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("initflush_timeout", (n >= 1000) ? 1 : 0, 0);
        chk("initflush_acks", acks - base_a, 1);
        chk("initflush_queue_left", exp_q.size(), 0);

        // Non-power-of-two geometry instance swept during the last init.
        chk("geo_grants", fires2, N2);
        chk("geo_max_idx", max2, N2 - 1);
        chk("geo_last_idx", last2, N2 - 1);
        chk("geo_init_done", init_done2, 1);
`ifndef CACHE_FLUSH_STALL_CNT_EN
        chk("stall_tied_zero", stall, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
